ps2_kbd_ctrl: RTL
=================

Name: ps2_kbd_ctrl

Overview:
APB-slave PS/2 keyboard controller that sequences a PS/2 frame receiver and buffers scan codes in a FIFO.
Adds a register map (data pop, status, control), sticky error flags, a frame-timeout recovery path and an interrupt.
Sits on the ysyxSoC APB peripheral bus next to the other perip blocks; drives the CPU interrupt line for keyboard input.

Parameters:
FIFO_DEPTH, 8, scan-code FIFO entries; power of 2, range 2..16.
TIMEOUT_CYC, 65535, clock cycles allowed between ps2_clk falling edges inside a frame before the frame is aborted; 16-bit.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
in_paddr  input  32  APB address; only [3:2] decoded
in_psel  input  1  APB select
in_penable  input  1  APB enable
in_pprot  input  3  ignored
in_pwrite  input  1  APB write
in_pwdata  input  32  APB write data
in_pstrb  input  4  ignored; full-word writes only
in_pready  output  1  APB ready
in_prdata  output  32  APB read data
in_pslverr  output  1  APB error
ps2_clk  input  1  PS/2 clock from pad, asynchronous
ps2_data  input  1  PS/2 data from pad, asynchronous
ps2_clk_oe  output  1  1 = pad pulls ps2_clk low (inhibit)
irq  output  1  level interrupt, registered

Behaviour:
- Reset: in_pready=0, in_prdata=0, in_pslverr=0, irq=0, ps2_clk_oe=0. FIFO empty, sticky flags 0, CTRL=0x1, receiver idle.
- APB timing: access phase = psel&penable. in_pready goes high in the 2nd access cycle (exactly one wait state), for one cycle only.
- APB commit: side effects (pop, register write, W1C) commit on the edge where psel&penable&pready. in_prdata and in_pslverr are valid while pready=1 and are 0 otherwise.
- Register map, selected by paddr[3:2]:
  - 0x0 DATA (RO): returns {23'b0, valid, code[7:0]}. If the FIFO is non-empty, valid=1 and the read pops the FIFO. If empty, returns 0 and does not pop. Writes are ignored.
  - 0x4 STATUS: [4:0] count, [5] empty, [6] full, [7] overflow (sticky), [8] frame_err (sticky), [9] inhibit. Writing 1 to bit 7 or bit 8 clears that bit.
  - 0x8 CTRL (RW): [0] rx_en, reset 1. [1] irq_en, reset 0. [2] flush: write-1 empties the FIFO; always reads 0.
  - 0xC: reads 0, pslverr=1, no side effect.
- Receiver:
  - ps2_clk and ps2_data go through 2-FF synchronizers. A sample is taken on the synchronized ps2_clk 1->0 edge.
  - Frame = 11 bits: start(0), d0..d7 LSB first, parity, stop(1).
  - Frame is good when start=0, stop=1 and the XOR of data and parity is 1 (odd parity). A good frame issues a 1-cycle push.
  - Any other completed frame pulses frame_err and pushes nothing.
- Timeout: while bitcount!=0, a counter runs and resets on each falling edge. Reaching TIMEOUT_CYC clears bitcount to 0 and sets frame_err.
- rx_en=0: receiver held idle (bitcount=0, counter=0); edges are ignored. Clearing rx_en mid-frame discards that frame.
- FIFO:
  - Push when full without a same-cycle pop: code dropped, overflow set.
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push on an empty FIFO: readable by DATA no earlier than the next APB access (no bypass).
  - Flush in the same cycle as a push: flush wins, the code is dropped, overflow is not set.
  - Pointers wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH.
- irq is registered: irq <= irq_en & (!empty | overflow | frame_err).
- A flag set and a W1C of that flag in the same cycle: the set wins.

Optional Feature:
- Macro: PS2_KBD_INHIBIT_EN.
- When defined: ps2_clk_oe is registered and equals full | !rx_en, so the device is inhibited and buffers internally. STATUS[9] mirrors ps2_clk_oe. Overflow can then arise only from a frame that is already in flight.
- When undefined: ps2_clk_oe is tied 0, STATUS[9] reads 0, and frames arriving while full are dropped with overflow set.

Decomposition:
- Package ps2_kbd_pkg holds:
  - register offset constants: DATA=2'd0, STAT=2'd1, CTRL=2'd2
  - STATUS and CTRL bit-index constants
  - FRAME_BITS=11
- Sub-module ps2_rx_frame contains the synchronizers, edge detect, bit shifter, parity/start/stop check and timeout.
  - Ports: clock, reset, en, ps2_clk, ps2_data, code[7:0], push, err.
- The FIFO and APB register logic stay in the top level.

Test Plan:
- Send a good frame with code 0x1C -> STATUS count=1, irq=1 after irq_en=1. DATA read returns 0x11C. The next DATA read returns 0x000 and count stays 0.
- Send frame 0x1C with a bad parity bit -> count stays 0, STATUS[8]=1. Writing 0x100 to STATUS clears bit 8.
- Without the macro, send 9 good frames 0x01..0x09 with FIFO_DEPTH=8 -> count=8, full=1, overflow=1. DATA reads return 0x101..0x108.
- Send 4 bits of a frame, then hold ps2_clk high for TIMEOUT_CYC cycles -> frame_err=1. A following good frame 0x5A is received correctly.
- With PS2_KBD_INHIBIT_EN, fill the FIFO -> ps2_clk_oe=1 and STATUS[9]=1. One DATA pop -> ps2_clk_oe=0 within 2 cycles.
- Push 3 frames, write CTRL=0x5 -> count=0, empty=1, CTRL reads 0x1. Access at offset 0xC -> pslverr=1 with pready. Every access shows pready on its 2nd access cycle.

Source files
------------

// File: rtl/ps2_kbd_ctrl_pkg.sv
// Shared constants for the PS/2 keyboard controller: register offsets,
// STATUS/CTRL bit positions, frame length and receiver state encoding.
package ps2_kbd_pkg;

    // Register offsets as decoded from paddr[3:2]
    localparam logic [1:0] DATA = 2'd0;
    localparam logic [1:0] STAT = 2'd1;
    localparam logic [1:0] CTRL = 2'd2;

    // STATUS bit positions
    localparam int unsigned STAT_CNT_LSB = 0;
    localparam int unsigned STAT_CNT_MSB = 4;
    localparam int unsigned STAT_EMPTY   = 5;
    localparam int unsigned STAT_FULL    = 6;
    localparam int unsigned STAT_OVF     = 7;
    localparam int unsigned STAT_FERR    = 8;
    localparam int unsigned STAT_INH     = 9;

    // CTRL bit positions
    localparam int unsigned CTRL_RX_EN  = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_FLUSH  = 2;

    // start + 8 data + parity + stop
    localparam int unsigned FRAME_BITS = 11;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_BUSY = 1'b1
    } rx_state_t;

    // Odd parity: data bits plus parity bit must XOR to 1
    function automatic logic odd_parity_ok(input logic [8:0] data_and_parity);
        return ^data_and_parity;
    endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// APB slave bus bundle for the PS/2 keyboard controller.
interface ps2_kbd_ctrl_if;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_penable;
    logic [2:0]  in_pprot;
    logic        in_pwrite;
    logic [31:0] in_pwdata;
    logic [3:0]  in_pstrb;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_pslverr;

    modport master (
        output in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
        input  in_pready, in_prdata, in_pslverr
    );

    modport slave (
        input  in_paddr, in_psel, in_penable, in_pprot, in_pwrite, in_pwdata, in_pstrb,
        output in_pready, in_prdata, in_pslverr
    );
endinterface

// File: rtl/ps2_kbd_ctrl_rx_frame.sv
// PS/2 frame receiver: synchronizes the pad signals, samples data on each
// ps2_clk falling edge, checks start/parity/stop and aborts stalled frames.
module ps2_rx_frame
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       push,
    output logic       err
);

    logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic ps2_data_p0, ps2_data_p1;
    logic fall;

    rx_state_t   state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [15:0] tmo_cnt, tmo_cnt_n;
    logic [9:0]  shift_sr, shift_sr_n;
    logic [7:0]  code_n;
    logic        push_n, err_n;
    logic        frame_ok;

    // Clock synchronizer plus one history stage for edge detect; idles high
    always_ff @(posedge clock) begin
        if (reset) begin
            ps2_clk_p0 <= 1'b1;
            ps2_clk_p1 <= 1'b1;
            ps2_clk_p2 <= 1'b1;
        end else begin
            ps2_clk_p0 <= ps2_clk;
            ps2_clk_p1 <= ps2_clk_p0;
            ps2_clk_p2 <= ps2_clk_p1;
        end
    end

    // Data synchronizer
    always_ff @(posedge clock) begin
        ps2_data_p0 <= ps2_data;
        ps2_data_p1 <= ps2_data_p0;
    end

    assign fall = ps2_clk_p2 & ~ps2_clk_p1;

    // shift_sr[0] holds the start bit once ten bits are in; the live sample is the stop bit
    assign frame_ok = ~shift_sr[0] & ps2_data_p1 & odd_parity_ok(shift_sr[9:1]);

    // Control state: bit counter, timeout counter, result pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RX_IDLE;
            bit_cnt <= 4'd0;
            tmo_cnt <= 16'd0;
            push    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            tmo_cnt <= tmo_cnt_n;
            push    <= push_n;
            err     <= err_n;
        end
    end

    // Datapath: shifted bits and the completed code
    always_ff @(posedge clock) begin
        shift_sr <= shift_sr_n;
        code     <= code_n;
    end

    // Next-state: collect bits on falling edges, finish on the 11th, abort on stall
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        tmo_cnt_n  = tmo_cnt;
        shift_sr_n = shift_sr;
        code_n     = code;
        push_n     = 1'b0;
        err_n      = 1'b0;
        if (!en) begin
            state_n   = RX_IDLE;
            bit_cnt_n = 4'd0;
            tmo_cnt_n = 16'd0;
        end else if (fall) begin
            tmo_cnt_n = 16'd0;
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                state_n   = RX_IDLE;
                bit_cnt_n = 4'd0;
                code_n    = shift_sr[8:1];
                push_n    = frame_ok;
                err_n     = ~frame_ok;
            end else begin
                state_n    = RX_BUSY;
                shift_sr_n = {ps2_data_p1, shift_sr[9:1]};
                bit_cnt_n  = bit_cnt + 4'd1;
            end
        end else if (state == RX_BUSY) begin
            if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
                state_n   = RX_IDLE;
                bit_cnt_n = 4'd0;
                tmo_cnt_n = 16'd0;
                err_n     = 1'b1;
            end else begin
                tmo_cnt_n = tmo_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// APB-slave PS/2 keyboard controller: frame receiver, scan-code FIFO,
// DATA/STATUS/CTRL registers, sticky error flags and a level interrupt.
// Build option: define PS2_KBD_INHIBIT_EN to drive ps2_clk_oe (inhibit the
// keyboard while the FIFO is full or reception is disabled).
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic           clock,
    input  logic           reset,
    ps2_kbd_ctrl_if.slave  apb,
    input  logic           ps2_clk,
    input  logic           ps2_data,
    output logic           ps2_clk_oe,
    output logic           irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [7:0]       rx_code;
    logic             rx_push, rx_err;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [4:0]       count5;
    logic             full, empty;
    logic             do_push, do_pop, ovf_set;

    logic             rx_en, irq_en;
    logic             ovf, ferr;
    logic             inhibit;

    logic [1:0]       reg_sel;
    logic             access, capture, commit, wr_commit, rd_commit;
    logic             pop, flush, w1c_ovf, w1c_ferr;
    logic [31:0]      rd_word;
    logic             unused_apb;

    ps2_rx_frame #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clock    (clock),
        .reset    (reset),
        .en       (rx_en),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .code     (rx_code),
        .push     (rx_push),
        .err      (rx_err)
    );

    assign reg_sel   = apb.in_paddr[3:2];
    assign access    = apb.in_psel & apb.in_penable;
    assign capture   = access & ~apb.in_pready;
    assign commit    = access & apb.in_pready;
    assign wr_commit = commit & apb.in_pwrite;
    assign rd_commit = commit & ~apb.in_pwrite;

    // The valid bit returned to the bus decides the pop, so an empty read never pops
    assign pop      = rd_commit & (reg_sel == DATA) & apb.in_prdata[8];
    assign flush    = wr_commit & (reg_sel == CTRL) & apb.in_pwdata[CTRL_FLUSH];
    assign w1c_ovf  = wr_commit & (reg_sel == STAT) & apb.in_pwdata[STAT_OVF];
    assign w1c_ferr = wr_commit & (reg_sel == STAT) & apb.in_pwdata[STAT_FERR];

    assign unused_apb = ^{apb.in_paddr[31:4], apb.in_paddr[1:0], apb.in_pprot,
                          apb.in_pstrb, apb.in_pwdata[31:9], apb.in_pwdata[6:3]};

    assign count5 = 5'(count);
    assign full   = (count == CNT_W'(FIFO_DEPTH));
    assign empty  = (count == '0);

    // A flush swallows a coincident push without flagging overflow
    assign do_push = rx_push & ~flush & (~full | pop);
    assign do_pop  = pop & ~flush;
    assign ovf_set = rx_push & ~flush & full & ~pop;

    // FIFO storage
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= rx_code;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as its clear wins
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovf  <= ovf_set | (ovf & ~w1c_ovf);
            ferr <= rx_err | (ferr & ~w1c_ferr);
        end
    end

    // CTRL register
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_en  <= 1'b1;
            irq_en <= 1'b0;
        end else if (wr_commit && reg_sel == CTRL) begin
            rx_en  <= apb.in_pwdata[CTRL_RX_EN];
            irq_en <= apb.in_pwdata[CTRL_IRQ_EN];
        end
    end

`ifdef PS2_KBD_INHIBIT_EN
    // Hold the keyboard off while there is nowhere to put a code
    always_ff @(posedge clock) begin
        if (reset) begin
            ps2_clk_oe <= 1'b0;
        end else begin
            ps2_clk_oe <= full | ~rx_en;
        end
    end
    assign inhibit = ps2_clk_oe;
`else
    assign ps2_clk_oe = 1'b0;
    assign inhibit    = 1'b0;
`endif

    // Register read mux
    always_comb begin
        rd_word = 32'd0;
        case (reg_sel)
            DATA: begin
                if (!empty) begin
                    rd_word = {23'd0, 1'b1, mem[rd_ptr]};
                end
            end
            STAT: begin
                rd_word[STAT_CNT_MSB:STAT_CNT_LSB] = count5;
                rd_word[STAT_EMPTY]                = empty;
                rd_word[STAT_FULL]                 = full;
                rd_word[STAT_OVF]                  = ovf;
                rd_word[STAT_FERR]                 = ferr;
                rd_word[STAT_INH]                  = inhibit;
            end
            CTRL: begin
                rd_word[CTRL_RX_EN]  = rx_en;
                rd_word[CTRL_IRQ_EN] = irq_en;
            end
            default: rd_word = 32'd0;
        endcase
    end

    // APB response: one wait state, read data and error held only while ready
    always_ff @(posedge clock) begin
        if (reset) begin
            apb.in_pready  <= 1'b0;
            apb.in_prdata  <= 32'd0;
            apb.in_pslverr <= 1'b0;
        end else begin
            apb.in_pready  <= capture;
            apb.in_prdata  <= (capture && !apb.in_pwrite) ? rd_word : 32'd0;
            apb.in_pslverr <= capture & (reg_sel == 2'd3);
        end
    end

    // Registered level interrupt
    always_ff @(posedge clock) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_en & (~empty | ovf | ferr);
        end
    end

endmodule
